vel_ramp: RTL



---
 rtl/vel_ramp.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vel_ramp.sv
// vel_ramp: speed-command front end for the PWM speed controller.
// Synchronises and debounces raw up/down buttons and a stop input, keeps a saturating
// target speed level and ramps the applied level toward it one step per STEP_CYCLES.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   up_i       raw speed-up button (async, active-high)
//   down_i     raw speed-down button (async, active-high)
//   stop_i     raw stop request level (async, active-high)
//   velCase_o  applied speed level, drives the PWM controller velCase input
//   target_o   requested speed level
//   ramping_o  high while the ramp FSM is stepping toward the target
module vel_ramp #(
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned STEP_CYCLES = 2500000,
  parameter int unsigned MAX_LEVEL   = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       stop_i,
  output logic [2:0] velCase_o,
  output logic [2:0] target_o,
  output logic       ramping_o
);

  localparam logic [15:0] DebLast  = 16'(DEB_CYCLES - 1);
  localparam logic [31:0] StepLast = 32'(STEP_CYCLES - 1);
  localparam logic [2:0]  MaxLvl   = 3'(MAX_LEVEL);

  typedef enum logic {StIdle, StRamp} state_e;

  // Bit 0 = up, bit 1 = down, bit 2 = stop.
  logic [2:0] sync1_q, sync2_q;

  // Debouncers, index 0 = up, index 1 = down.
  logic [1:0][15:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]       deb_lvl_q, deb_lvl_d;
  logic [1:0]       deb_prev_q;
  logic [1:0]       press_q;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  vel_q, vel_d;
  logic [2:0]  target_q, target_d;
  logic [2:0]  step_vel;
  logic        stop_s;

  assign stop_s = sync2_q[2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      deb_lvl_d[i] = deb_lvl_q[i];
      if (sync2_q[i] != deb_lvl_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_lvl_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    target_d = target_q;
    vel_d    = vel_q;
    state_d  = state_q;
    timer_d  = timer_q;
    // Direction is recomputed from the live target every step.
    step_vel = (target_q > vel_q) ? vel_q + 3'd1 : vel_q - 3'd1;

    if (stop_s) begin
      // Hard stop: no ramp-down, presses dropped.
      target_d = '0;
      vel_d    = '0;
      state_d  = StIdle;
      timer_d  = '0;
    end else begin
      // Simultaneous up and down pulses cancel.
      if (press_q[0] && !press_q[1] && (target_q < MaxLvl)) begin
        target_d = target_q + 3'd1;
      end else if (press_q[1] && !press_q[0] && (target_q != 3'd0)) begin
        target_d = target_q - 3'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (target_q != vel_q) begin
            state_d = StRamp;
            timer_d = '0;
          end
        end
        StRamp: begin
          if (target_q == vel_q) begin
            state_d = StIdle;
            timer_d = '0;
          end else if (timer_q == StepLast) begin
            vel_d   = step_vel;
            timer_d = '0;
            if (step_vel == target_q) begin
              state_d = StIdle;
            end
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_cnt_q  <= '0;
      deb_lvl_q  <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      state_q    <= StIdle;
      timer_q    <= '0;
      vel_q      <= '0;
      target_q   <= '0;
    end else begin
      sync1_q    <= {stop_i, down_i, up_i};
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_prev_q <= deb_lvl_q;
      // Rising edge of the debounced level only; releases and holds give nothing.
      press_q    <= deb_lvl_q & ~deb_prev_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      vel_q      <= vel_d;
      target_q   <= target_d;
    end
  end

  assign velCase_o = vel_q;
  assign target_o  = target_q;
  assign ramping_o = (state_q == StRamp);

endmodule
